// File: rtl/alu_shift_pkg.sv
// Shared types and sizes for the ALU shifter units.
package alu_shift_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } shift_state_t;

    localparam int SHIFT_WIDTH  = 32;
    localparam int SHIFT_STAGES = 5;

endpackage

// File: rtl/rightshift_seq_if.sv
// Operand/result handshake bundle for the sequential right shifter.
interface rightshift_seq_if
    import alu_shift_pkg::*;
#(
    parameter int WIDTH = SHIFT_WIDTH,
    parameter int SHW   = SHIFT_STAGES
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [SHW-1:0]   b;
    logic             arith;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;

    // Requester/consumer side.
    modport master (
        output in_valid, a, b, arith, out_ready,
        input  in_ready, out_valid, out
    );

    // Shifter side.
    modport slave (
        input  in_valid, a, b, arith, out_ready,
        output in_ready, out_valid, out
    );
endinterface

// File: rtl/rshift_stage.sv
// One barrel stage: shifts d right by 2**stg when en is set, filling with fill.
module rshift_stage
    import alu_shift_pkg::*;
#(
    parameter int WIDTH = SHIFT_WIDTH,
    parameter int SHW   = SHIFT_STAGES,
    parameter int STW   = $clog2(SHW)
) (
    input  logic [WIDTH-1:0] d,
    input  logic [STW-1:0]   stg,
    input  logic             en,
    input  logic             fill,
    output logic [WIDTH-1:0] q
);
    localparam logic [WIDTH-1:0] ONES = '1;

    // Select the shift distance for the current stage and merge in the fill bits.
    always_comb begin
        q = d;
        if (en) begin
            for (int i = 0; i < SHW; i++) begin
                if (stg == STW'(i)) begin
                    q = (d >> (1 << i)) | ({WIDTH{fill}} & ~(ONES >> (1 << i)));
                end
            end
        end
    end
endmodule

// File: rtl/rightshift_seq.sv
// Sequential right shifter: resolves one bit of the shift amount per clock.
//   state | meaning
//   IDLE  | ready for a new operand, in_ready=1
//   SHIFT | applying barrel stage stg (1,2,4,8,16)
//   DONE  | result held on out until consumer takes it
module rightshift_seq
    import alu_shift_pkg::*;
#(
    parameter int WIDTH = SHIFT_WIDTH,
    parameter int SHW   = SHIFT_STAGES
) (
    input  logic            clk,
    input  logic            rst_n,
    rightshift_seq_if.slave bus
);
    localparam int STW = $clog2(SHW);

    shift_state_t     state_q, state_d;
    logic [STW-1:0]   stg_q, stg_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [SHW-1:0]   b_q, b_d;
    logic             fill_q, fill_d;
    logic [WIDTH-1:0] stage_out;

    rshift_stage #(
        .WIDTH (WIDTH),
        .SHW   (SHW),
        .STW   (STW)
    ) u_stage (
        .d    (a_q),
        .stg  (stg_q),
        .en   (b_q[stg_q]),
        .fill (fill_q),
        .q    (stage_out)
    );

    // Next-state and datapath update; sign is sampled once at capture.
    always_comb begin
        state_d = state_q;
        stg_d   = stg_q;
        a_d     = a_q;
        b_d     = b_q;
        fill_d  = fill_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    fill_d  = bus.arith & bus.a[WIDTH-1];
                    stg_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                a_d = stage_out;
                if (stg_q == STW'(SHW - 1)) begin
                    state_d = DONE;
                end else begin
                    stg_d = stg_q + 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and data registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            stg_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            fill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            stg_q   <= stg_d;
            a_q     <= a_d;
            b_q     <= b_d;
            fill_q  <= fill_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out       = a_q;
endmodule

// File: tb/tb_rightshift_seq.sv
// Directed and swept checks of rightshift_seq against a behavioural shift model.
module tb_rightshift_seq;
    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] exp_q[$];

    rightshift_seq_if bus ();

    rightshift_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] ref_shift(input logic [31:0] av, input logic [4:0] bv,
                                              input logic ar);
        if (ar) return 32'($signed(av) >>> bv);
        return av >> bv;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Wait for in_ready, present one operation, push its expected result.
    task automatic send(input logic [31:0] av, input logic [4:0] bv, input logic ar,
                        input logic [31:0] exp);
        int n = 0;
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("send_in_ready", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.a        = av;
        bus.b        = bv;
        bus.arith    = ar;
        exp_q.push_back(exp);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.a        = $urandom;
        bus.b        = 5'($urandom);
        bus.arith    = 1'($urandom);
    endtask

    // Wait for the result, check latency/value, stall, then consume.
    task automatic finish_op(input string tag, input int stall);
        int          lat = 0;
        logic [31:0] held;
        logic [31:0] exp;
        while (!bus.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'd5);
        check({tag, "_queue"}, 32'(exp_q.size() > 0), 32'd1);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
        check({tag, "_out"}, bus.out, exp);
        held = bus.out;
        for (int i = 0; i < stall; i++) begin
            bus.in_valid = 1'($urandom);
            bus.a        = $urandom;
            bus.b        = 5'($urandom);
            bus.arith    = 1'($urandom);
            @(negedge clk);
            check({tag, "_stall_out"}, bus.out, held);
            check({tag, "_stall_valid"}, 32'(bus.out_valid), 32'd1);
            check({tag, "_stall_in_ready"}, 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, "_idle_in_ready"}, 32'(bus.in_ready), 32'd1);
        check({tag, "_idle_out_valid"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] ra;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.arith     = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_in_ready", 32'(bus.in_ready), 32'd1);
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_out", bus.out, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        send(32'h8000_0000, 5'd31, 1'b0, 32'h0000_0001);
        finish_op("logical_31", 0);
        send(32'h8000_0000, 5'd31, 1'b1, 32'hFFFF_FFFF);
        finish_op("arith_31", 0);
        send(32'h8000_0000, 5'd4, 1'b1, 32'hF800_0000);
        finish_op("arith_4", 0);
        send(32'hF0F0_1234, 5'd0, 1'b1, 32'hF0F0_1234);
        finish_op("zero_shift", 0);
        send(32'hF0F0_1234, 5'd4, 1'b0, 32'h0F0F_0123);
        finish_op("logical_4", 0);
        send(32'h7654_3210, 5'd5, 1'b1, 32'h03B2_A190);
        finish_op("backpressure", 3);

        // Reset while stage 2 is pending: in-flight op is discarded.
        send(32'hDEAD_BEEF, 5'd31, 1'b1, 32'hFFFF_FFFF);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midreset_in_ready", 32'(bus.in_ready), 32'd1);
        check("midreset_out_valid", 32'(bus.out_valid), 32'd0);
        check("midreset_out", bus.out, 32'd0);
        exp_q.delete();
        rst_n = 1'b1;
        send(32'h0000_0100, 5'd8, 1'b0, 32'h0000_0001);
        finish_op("after_reset", 0);

        for (int bi = 0; bi < 32; bi++) begin
            for (int ar = 0; ar < 2; ar++) begin
                ra = $urandom;
                if ((bi % 3) == 0) ra[31] = 1'b1;
                send(ra, 5'(bi), 1'(ar), ref_shift(ra, 5'(bi), 1'(ar)));
                finish_op("sweep", int'($urandom_range(0, 3)));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rightshift_seq.md
# rightshift_seq

Sequential 32-bit right shifter for the ALU datapath: logical or arithmetic shift of operand `a` by `b` positions (0–31). It resolves one bit of `b` per clock, applying barrel stages of 1, 2, 4, 8 and 16, which keeps the per-cycle logic to a single mux stage. It has valid/ready handshakes on both input and output, so the ALU control can stall it and treat it like the other multi-cycle units.

## Interface
- `WIDTH`, default 32: operand and result width; fixed at 32 for this ALU.
- `SHW`, default 5: shift-amount width, equal to log2(WIDTH).
- `clk`  in  1: single clock; every flop is rising-edge.
- `rst_n`  in  1: reset, synchronous and active-low.
- `in_valid`  in  1: the requester presents `a`, `b` and `arith`.
- `in_ready`  out  1: the block can accept an operation; high only in IDLE.
- `a`  in  WIDTH: operand to shift.
- `b`  in  SHW: shift amount, unsigned.
- `arith`  in  1: 1 selects arithmetic shift (sign-fill); 0 selects logical shift (zero-fill).
- `out_valid`  out  1: `out` holds a finished result.
- `out_ready`  in  1: the consumer takes the result.
- `out`  out  WIDTH: the shifted result.

## Operation
- **States:** IDLE, SHIFT, DONE.
- **IDLE:**
  - `in_ready`=1.
  - When `in_valid` is high, capture `a_r<=a`, `b_r<=b`, `fill<=arith & a[WIDTH-1]`, `stg<=0`, then go to SHIFT.
- **SHIFT:** at each edge, stage `i`=`stg`:
  - If `b_r[i]`, then `a_r <= {{2^i{fill}}, a_r[WIDTH-1:2^i]}`; otherwise `a_r` holds.
  - `stg` increments.
  - When `stg`==SHW-1, the transition is to DONE instead of incrementing.
- **DONE:**
  - `out_valid`=1 and `out`=`a_r`.
  - While `out_ready` is low, hold everything stable.
  - When `out_ready` is high, go to IDLE.
- **Arithmetic rules:**
  - The sign is sampled once at capture.
  - The fill bit is constant across all stages.
  - Logical mode always fills with 0.
- **Result:** equals `$signed(a)>>>b` when `arith`=1, and `a>>b` when `arith`=0.
- **`b`=0:** no stage shifts, but the full latency still applies; the result is `a`.
- **Input changes after capture:** changes to `a`, `b` or `arith` during SHIFT or DONE are ignored.
- **Ready in busy states:** `in_valid` is ignored while `in_ready`=0.
- **`out` in IDLE and SHIFT:** `out` shows `a_r` (intermediate value) and must not be consumed.

## Timing
- **Reset** (`rst_n` low at an edge):
  - State goes to IDLE; `stg`=0, `a_r`=0, `b_r`=0, `fill`=0.
  - Outputs after reset: `in_ready`=1, `out_valid`=0, `out`=0.
  - This applies from any state, including mid-SHIFT and DONE; the in-flight operation is discarded.
- **Latency:** if the input handshake occurs at edge E0, stages execute at edges E1..E5, and `out_valid` is high in the cycle following E5.
- **Result handshake:** if `out_ready` is high in that cycle, the handshake completes at E6 and `in_ready` is high after E6.
- **Throughput:** one operation per 7 cycles at best; a new operation is accepted at the earliest at E7.
- **Back-to-back boundary:** `in_valid` held high during DONE is not accepted until the IDLE cycle.
- **Outputs:** `in_ready` and `out_valid` are decoded directly from state registers, with no combinational path from inputs.
- **Backpressure:** under stalled `out_ready`, `out` and `out_valid` are stable indefinitely.

## Structure
- **Package `alu_shift_pkg`:**
  - State enum `shift_state_t` {IDLE, SHIFT, DONE}.
  - Localparams `SHIFT_WIDTH=32` and `SHIFT_STAGES=5`.
  - Shared with the left shifter's rework.
- **Sub-module `rshift_stage`:** the natural sub-module. It is combinational, with inputs `d`, `stg`, `en` and `fill`, and output the shifted `d`; the FSM registers its output.
- **Registers:** the FSM, `stg` counter and data registers stay in the top module.

## Test plan
- **Logical long shift:** `a`=0x8000_0000, `b`=31, `arith`=0 -> `out`=0x0000_0001; `out_valid` rises in the 5th cycle after the accept edge.
- **Arithmetic long shift:** `a`=0x8000_0000, `b`=31, `arith`=1 -> `out`=0xFFFF_FFFF. Same `a` with `b`=4 -> 0xF800_0000.
- **Zero shift amount:** `a`=0xF0F0_1234, `b`=0, `arith`=1 -> 0xF0F0_1234 with the same 5-cycle latency. Then `b`=4, `arith`=0 -> 0x0F0F_0123.
- **Backpressure:**
  - Hold `out_ready`=0 for 3 cycles in DONE while toggling `a`, `b` and `in_valid`.
  - Required: `out` is stable, `in_ready`=0, and no new capture occurs.
  - Release: `out_ready`=1 -> IDLE next cycle.
- **Reset mid-operation:**
  - Drive `rst_n`=0 at stage 2 of a `b`=31 operation.
  - Required: after that edge, `in_ready`=1, `out_valid`=0, `out`=0.
  - A next op `a`=0x0000_0100, `b`=8, `arith`=0 -> 0x0000_0001.
- **Exhaustive sweep:** random `a`, all `b` 0..31, both `arith` values, with `out_ready` randomly throttled -> every result matches the reference model; the valid/ready protocol is never violated.
